// File: rtl/alu_result_framer_if.sv
// ALU-result / UART-transmitter handshake bundle for alu_result_framer.
// slave = the framer, master = whatever drives results and consumes bytes.
interface alu_result_framer_if #(
  parameter int RES_WIDTH  = 16,
  parameter int BYTE_WIDTH = 8
);
  logic [RES_WIDTH-1:0]  ALU_OUT;
  logic                  OUT_VALID;
  logic                  TX_BUSY;
  logic [BYTE_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  FRAMER_BUSY;
  logic [3:0]            DROP_CNT;

  modport master (
    output ALU_OUT, OUT_VALID, TX_BUSY,
    input  TX_P_DATA, TX_D_VLD, FRAMER_BUSY, DROP_CNT
  );

  modport slave (
    input  ALU_OUT, OUT_VALID, TX_BUSY,
    output TX_P_DATA, TX_D_VLD, FRAMER_BUSY, DROP_CNT
  );
endinterface

// File: rtl/alu_result_framer.sv
// Buffers ALU results in a 2-deep FIFO and serialises each one as two bytes,
// low byte first, to a UART transmitter with busy/valid handshake.
module alu_result_framer #(
  parameter int RES_WIDTH  = 16,
  parameter int BYTE_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  alu_result_framer_if.slave fr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND_LO = 2'd1;
  localparam logic [1:0] SEND_HI = 2'd2;

  logic [1:0]           r_state;
  logic [RES_WIDTH-1:0] r_mem [2];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_count;
  logic [3:0]           r_drop;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_drop;
  logic [RES_WIDTH-1:0]  w_head;
  logic [BYTE_WIDTH-1:0] w_byte;

  assign w_full  = (r_count == 2'd2);
  assign w_empty = (r_count == 2'd0);
  assign w_pop   = (r_state == SEND_HI) && !fr.TX_BUSY;
  // A pop on the same edge frees the head slot, so a full FIFO can still take the write.
  assign w_wr    = fr.OUT_VALID && (!w_full || w_pop);
  assign w_drop  = fr.OUT_VALID && w_full && !w_pop;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_drop  <= '0;
    end else begin
      case (r_state)
        IDLE:    if (!w_empty) r_state <= SEND_LO;
        SEND_LO: if (!fr.TX_BUSY) r_state <= SEND_HI;
        SEND_HI: if (!fr.TX_BUSY) r_state <= ((r_count > 2'd1) || w_wr) ? SEND_LO : IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_wr)  r_wptr <= ~r_wptr;
      if (w_pop) r_rptr <= ~r_rptr;

      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      if (w_drop && (r_drop != 4'hF)) r_drop <= r_drop + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wptr] <= fr.ALU_OUT;
  end

  always_comb begin
    w_byte = '0;
    case (r_state)
      SEND_LO: w_byte = w_head[BYTE_WIDTH-1:0];
      SEND_HI: w_byte = w_head[RES_WIDTH-1:BYTE_WIDTH];
      default: w_byte = '0;
    endcase
  end

  assign fr.TX_P_DATA   = w_byte;
  assign fr.TX_D_VLD    = (r_state != IDLE);
  assign fr.FRAMER_BUSY = !w_empty || (r_state != IDLE);
  assign fr.DROP_CNT    = r_drop;

endmodule
